biriscv_branch_sched: RTL



---
 rtl/biriscv_branch_sched.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/biriscv_branch_sched.sv
// biriscv_branch_sched
//
// Branch scheduler between the two execute lanes and the fetch / branch
// predictor front end of the dual-issue core.
//   * Arbitrates same-cycle early redirects from lane 0 (older) and lane 1
//     (younger) into one registered fetch redirect. The redirect is held
//     until fetch accepts it. A newer redirect overwrites a pending one.
//   * Serialises resolved-branch updates from both lanes through a small
//     FIFO into the single-ported predictor update interface.
//   * Back-pressures issue when the FIFO cannot absorb a dual update.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   laneN_d_request_i/pc_i/priv_i early redirect request from lane N
//   fetch_accept_i                fetch consumes the presented redirect
//   fetch_branch_o/pc_o/priv_o    pending redirect to fetch
//   squash_lane1_o                kill this cycle's lane-1 instruction
//   laneN_upd_*_i                 resolved-branch update from lane N
//   bp_valid_o, bp_ready_i        predictor update handshake (FIFO head)
//   bp_taken_o/source_o/pc_o/type_o  head entry fields
//   stall_o                       fewer than two free FIFO entries
//   overflow_o                    sticky: an update was dropped on a full FIFO
module biriscv_branch_sched #(
  parameter int unsigned UPDATE_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        lane0_d_request_i,
  input  logic [31:0] lane0_d_pc_i,
  input  logic [1:0]  lane0_d_priv_i,
  input  logic        lane1_d_request_i,
  input  logic [31:0] lane1_d_pc_i,
  input  logic [1:0]  lane1_d_priv_i,

  input  logic        fetch_accept_i,
  output logic        fetch_branch_o,
  output logic [31:0] fetch_branch_pc_o,
  output logic [1:0]  fetch_branch_priv_o,
  output logic        squash_lane1_o,

  input  logic        lane0_upd_valid_i,
  input  logic        lane0_upd_taken_i,
  input  logic [31:0] lane0_upd_source_i,
  input  logic [31:0] lane0_upd_pc_i,
  input  logic [2:0]  lane0_upd_type_i,
  input  logic        lane1_upd_valid_i,
  input  logic        lane1_upd_taken_i,
  input  logic [31:0] lane1_upd_source_i,
  input  logic [31:0] lane1_upd_pc_i,
  input  logic [2:0]  lane1_upd_type_i,

  output logic        bp_valid_o,
  input  logic        bp_ready_i,
  output logic        bp_taken_o,
  output logic [31:0] bp_source_o,
  output logic [31:0] bp_pc_o,
  output logic [2:0]  bp_type_o,

  output logic        stall_o,
  output logic        overflow_o
);

  localparam int unsigned PW = $clog2(UPDATE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(UPDATE_DEPTH);

  // --------------------------------------------------------------------------
  // Redirect FSM
  // --------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cap_pc_q, cap_pc_d;
  logic [1:0]  cap_priv_q, cap_priv_d;

  logic        cand_valid;
  logic [31:0] cand_pc;
  logic [1:0]  cand_priv;

  // Lane 0 is older, so its redirect wins and lane 1 is squashed.
  always_comb begin
    cand_valid = lane0_d_request_i | lane1_d_request_i;
    cand_pc    = lane0_d_request_i ? lane0_d_pc_i   : lane1_d_pc_i;
    cand_priv  = lane0_d_request_i ? lane0_d_priv_i : lane1_d_priv_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cap_pc_q   <= '0;
      cap_priv_q <= '0;
    end else begin
      state_q    <= state_d;
      cap_pc_q   <= cap_pc_d;
      cap_priv_q <= cap_priv_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_pc_d   = cap_pc_q;
    cap_priv_d = cap_priv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cand_valid) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        // A new candidate supersedes the pending one even if fetch accepts
        // the old one in the same cycle.
        if (cand_valid)          state_d = ST_PENDING;
        else if (fetch_accept_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (cand_valid) begin
      cap_pc_d   = cand_pc;
      cap_priv_d = cand_priv;
    end
  end

  always_comb begin
    fetch_branch_o      = (state_q == ST_PENDING);
    fetch_branch_pc_o   = cap_pc_q;
    fetch_branch_priv_o = cap_priv_q;
    squash_lane1_o      = lane0_d_request_i;
  end

  // --------------------------------------------------------------------------
  // Update FIFO
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic        taken;
    logic [31:0] source;
    logic [31:0] pc;
    logic [2:0]  br_type;
  } upd_t;

  upd_t          mem_q [UPDATE_DEPTH];
  upd_t          mem_d [UPDATE_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          pop;
  logic          push0_ok, push1_ok;
  logic [CW-1:0] free0, free1;
  logic [PW-1:0] wr1_ptr;
  upd_t          entry0, entry1;

  always_comb begin
    entry0 = '{taken: lane0_upd_taken_i, source: lane0_upd_source_i,
               pc: lane0_upd_pc_i, br_type: lane0_upd_type_i};
    entry1 = '{taken: lane1_upd_taken_i, source: lane1_upd_source_i,
               pc: lane1_upd_pc_i, br_type: lane1_upd_type_i};

    pop = (count_q != '0) & bp_ready_i;

    // The popped slot is available to this cycle's pushes; lane 1 only
    // sees what remains after lane 0 has been placed.
    free0    = DEPTH_C - count_q + CW'(pop);
    push0_ok = lane0_upd_valid_i & (free0 != '0);
    free1    = free0 - CW'(push0_ok);
    push1_ok = lane1_upd_valid_i & (free1 != '0);
    wr1_ptr  = wr_ptr_q + PW'(push0_ok);

    mem_d = mem_q;
    if (push0_ok) mem_d[wr_ptr_q] = entry0;
    if (push1_ok) mem_d[wr1_ptr]  = entry1;

    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push0_ok) + PW'(push1_ok);
    count_d    = count_q - CW'(pop) + CW'(push0_ok) + CW'(push1_ok);
    overflow_d = overflow_q
               | (lane0_upd_valid_i & ~push0_ok)
               | (lane1_upd_valid_i & ~push1_ok);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < UPDATE_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < UPDATE_DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    bp_valid_o  = (count_q != '0);
    bp_taken_o  = mem_q[rd_ptr_q].taken;
    bp_source_o = mem_q[rd_ptr_q].source;
    bp_pc_o     = mem_q[rd_ptr_q].pc;
    bp_type_o   = mem_q[rd_ptr_q].br_type;
    stall_o     = (DEPTH_C - count_q) < CW'(2);
    overflow_o  = overflow_q;
  end

endmodule
